idct_transpose: RTL and testbench

- Ping-pong transpose buffer between the row IDCT stage and the column IDCT stage.
- Captures row-stage results serially, one sample per cycle in row-major order.
- Once a block is complete, replays it in column-major order to the column stage.
- Supports 8x8 and 4x4 blocks, with valid/ready handshakes on both sides so writing one bank overlaps reading the other.

---
 rtl/idct_pkg.sv | 10 +
 rtl/idct_tp_mem.sv | 21 ++
 rtl/idct_transpose.sv | 101 ++++++++++
 tb/tb_idct_transpose.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// idct_pkg: shared size codes, widths and block-dimension helper for the IDCT transpose buffer
package idct_pkg;
  localparam int N_MAX = 8;
  localparam int WIDTH_X = 16;
  localparam logic [1:0] SIZE_4X4 = 2'b01;
  localparam logic [1:0] SIZE_8X8 = 2'b10;
  function automatic logic [3:0] dim(input logic [1:0] size);
    return size == SIZE_8X8 ? 4'd8 : 4'd4;
  endfunction
endpackage

// File: rtl/idct_tp_mem.sv
// idct_tp_mem: two-bank sample store with one write port and one asynchronous read port
// Ports: clk; i_we/i_wbank/i_waddr/i_wdata write port; i_rbank/i_raddr -> o_rdata read port.
module idct_tp_mem #(
  parameter int W = idct_pkg::WIDTH_X,
  parameter int D = idct_pkg::N_MAX * idct_pkg::N_MAX,
  localparam int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_wbank,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_rbank,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [2][D];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_wbank][i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_rbank][i_raddr];
endmodule

// File: rtl/idct_transpose.sv
// idct_transpose: ping-pong buffer taking row-major samples and replaying each block column-major
// Ports: clk, rst_n (sync, active-low); write side in_valid/in_ready/in_data/in_size;
// read side out_valid/out_ready/out_data/out_size/out_first (column start)/out_last (block end).
module idct_transpose #(
  parameter int WIDTH_X = idct_pkg::WIDTH_X,
  parameter int N_MAX = idct_pkg::N_MAX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_X-1:0] in_data,
  input  logic [1:0]         in_size,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_X-1:0] out_data,
  output logic [1:0]         out_size,
  output logic               out_first,
  output logic               out_last
);
  import idct_pkg::*;
  localparam int AW = $clog2(N_MAX * N_MAX);
  localparam logic [AW-1:0] NM = AW'(N_MAX);
  logic               r_wr_bank, r_rd_bank;
  logic [AW-1:0]      r_wr_cnt, r_rd_cnt;
  logic [1:0]         r_full;
  logic [1:0]         r_size [2];
  logic [1:0]         w_wsize, w_rsize, w_wsh, w_rsh;
  logic [AW-1:0]      w_wn, w_rn, w_waddr, w_raddr, w_rr;
  logic               w_we, w_wlast, w_rlast, w_ld;
  logic [WIDTH_X-1:0] w_rdata;
  assign in_ready = !r_full[r_wr_bank];
  // Size comes from the live input only on the first sample of a block; N is 4 or 8 so
  // row/column splits are shifts and masks.
  always_comb begin
    w_wsize = r_wr_cnt == '0 ? in_size : r_size[r_wr_bank];
    w_wn = AW'(dim(w_wsize));
    w_wsh = w_wsize == SIZE_8X8 ? 2'd3 : 2'd2;
    w_we = in_valid && in_ready && (w_wsize == SIZE_4X4 || w_wsize == SIZE_8X8);
    w_waddr = (r_wr_cnt >> w_wsh) * NM + (r_wr_cnt & (w_wn - AW'(1)));
    w_wlast = r_wr_cnt == w_wn * w_wn - AW'(1);
    w_rsize = r_size[r_rd_bank];
    w_rn = AW'(dim(w_rsize));
    w_rsh = w_rsize == SIZE_8X8 ? 2'd3 : 2'd2;
    w_rr = r_rd_cnt & (w_rn - AW'(1));
    w_raddr = w_rr * NM + (r_rd_cnt >> w_rsh);
    w_rlast = r_rd_cnt == w_rn * w_rn - AW'(1);
    w_ld = r_full[r_rd_bank] && (!out_valid || out_ready);
  end
  idct_tp_mem #(.W(WIDTH_X), .D(N_MAX * N_MAX)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_wbank (r_wr_bank),
    .i_waddr (w_waddr),
    .i_wdata (in_data),
    .i_rbank (r_rd_bank),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );
  // Writer and reader never touch the same bank's full flag on one edge: the writer needs it
  // clear, the reader needs it set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_full <= '0;
      r_size[0] <= '0;
      r_size[1] <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_size <= '0;
      out_first <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (w_we) begin
        if (r_wr_cnt == '0) r_size[r_wr_bank] <= in_size;
        r_wr_cnt <= w_wlast ? '0 : r_wr_cnt + AW'(1);
        if (w_wlast) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank <= !r_wr_bank;
        end
      end
      if (w_ld) begin
        out_valid <= 1'b1;
        out_data <= w_rdata;
        out_size <= w_rsize;
        out_first <= w_rr == '0;
        out_last <= w_rlast;
        r_rd_cnt <= w_rlast ? '0 : r_rd_cnt + AW'(1);
        if (w_rlast) begin
          r_full[r_rd_bank] <= 1'b0;
          r_rd_bank <= !r_rd_bank;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_idct_transpose.sv
// tb_idct_transpose: directed checks of the transpose buffer ordering, handshakes and reset
module tb_idct_transpose;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_first, out_last;
  logic [15:0] in_data, out_data;
  logic [1:0]  in_size, out_size;
  int          errors = 0;
  int          checks = 0;
  int          cnt, rd_i;
  always #5 clk = ~clk;
  idct_transpose dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_size   (in_size),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_size  (out_size),
    .out_first (out_first),
    .out_last  (out_last)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int col8(input int i);
    return (i / 64) * 64 + ((i % 64) % 8) * 8 + (i % 64) / 8;
  endfunction
  task automatic write_block(input int n, input int base);
    for (int k = 0; k < n * n; k++) begin
      in_valid = 1'b1;
      in_data = 16'(base + k);
      in_size = n == 8 ? 2'b10 : 2'b01;
      chk("wr_ready", int'(in_ready), 1);
      step();
    end
    in_valid = 1'b0;
  endtask
  task automatic read_block(input int n, input int base);
    out_ready = 1'b1;
    step();
    for (int j = 0; j < n * n; j++) begin
      chk("rd_valid", int'(out_valid), 1);
      chk("rd_data", int'(out_data), base + (j % n) * n + j / n);
      chk("rd_first", int'(out_first), int'(j % n == 0));
      chk("rd_last", int'(out_last), int'(j == n * n - 1));
      chk("rd_size", int'(out_size), n == 8 ? 2 : 1);
      step();
    end
    chk("rd_idle", int'(out_valid), 0);
  endtask
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_size = '0;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_size", int'(out_size), 0);
    chk("rst_first", int'(out_first), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_ready", int'(in_ready), 1);
    write_block(8, 0);
    chk("latency", int'(out_valid), 0);
    read_block(8, 0);
    write_block(4, 0);
    read_block(4, 0);
    for (int t = 0; t < 194; t++) begin
      if (t < 128) begin
        in_valid = 1'b1;
        in_data = 16'(t);
        in_size = 2'b10;
        chk("b2b_ready", int'(in_ready), 1);
      end else begin
        in_valid = 1'b0;
      end
      if (t >= 65 && t < 193) begin
        chk("b2b_valid", int'(out_valid), 1);
        chk("b2b_data", int'(out_data), col8(t - 65));
        chk("b2b_first", int'(out_first), int'((t - 65) % 8 == 0));
        chk("b2b_last", int'(out_last), int'((t - 65) % 64 == 63));
      end else begin
        chk("b2b_idle", int'(out_valid), 0);
      end
      step();
    end
    out_ready = 1'b0;
    cnt = 0;
    for (int it = 0; it < 150; it++) begin
      chk("stall_ready", int'(in_ready), int'(cnt < 128));
      in_valid = 1'b1;
      in_data = 16'(cnt);
      in_size = 2'b10;
      if (in_ready) cnt++;
      step();
    end
    chk("stall_cnt", cnt, 128);
    chk("stall_valid", int'(out_valid), 1);
    chk("stall_data", int'(out_data), 0);
    chk("stall_first", int'(out_first), 1);
    out_ready = 1'b1;
    rd_i = 0;
    for (int it = 0; it < 400 && rd_i < 192; it++) begin
      if (rd_i <= 63) chk("release_ready", int'(in_ready), int'(rd_i >= 63));
      chk("drain_valid", int'(out_valid), 1);
      if (out_valid) begin
        chk("drain_data", int'(out_data), col8(rd_i));
        chk("drain_last", int'(out_last), int'(rd_i % 64 == 63));
        rd_i++;
      end
      if (cnt < 192) begin
        in_valid = 1'b1;
        in_data = 16'(cnt);
      end else begin
        in_valid = 1'b0;
      end
      if (in_ready && cnt < 192) cnt++;
      step();
    end
    in_valid = 1'b0;
    chk("drain_count", rd_i, 192);
    chk("drain_wr", cnt, 192);
    chk("drain_idle", int'(out_valid), 0);
    in_valid = 1'b1;
    in_size = 2'b00;
    in_data = 16'd55;
    chk("bad_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bad_novalid", int'(out_valid), 0);
      step();
    end
    write_block(4, 0);
    read_block(4, 0);
    for (int k = 0; k < 30; k++) begin
      in_valid = 1'b1;
      in_data = 16'(500 + k);
      in_size = 2'b10;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    chk("mid_rst_data", int'(out_data), 0);
    step();
    step();
    chk("mid_rst_idle", int'(out_valid), 0);
    write_block(4, 100);
    read_block(4, 100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
